// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode encodings, execute-stage states
// and the opcode write-enable classification used by the execute stage.
package cpu_pkg;

  localparam int DW      = 8;
  localparam int SHAMT_W = 3;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADC  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_PASS = 4'd6,
    OP_CMP  = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_MUL  = 4'd10
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic op_writes_reg(op_t op);
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_PASS, OP_SHL, OP_SHR, OP_MUL: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic logic op_writes_carry(op_t op);
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SHL, OP_SHR, OP_MUL, OP_CMP: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exec_unit_if.sv
// Controller/reg_file <-> execute-stage bundle: request, operands, handshake and
// write-back signals. The controller side is the master.
interface exec_unit_if;
  import cpu_pkg::*;

  logic          start;
  op_t           op;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;
  logic          cin;
  logic          busy;
  logic          done;
  logic [DW-1:0] write_data;
  logic          cout_data;
  logic          write_enable;
  logic          cout_write_enable;

  modport master (
    output start, op, rs_val, rt_val, cin,
    input  busy, done, write_data, cout_data, write_enable, cout_write_enable
  );

  modport slave (
    input  start, op, rs_val, rt_val, cin,
    output busy, done, write_data, cout_data, write_enable, cout_write_enable
  );

endinterface

// File: rtl/mul8_iter.sv
// Iterative shift-add multiplier: load captures the operands, each step adds the
// shifted multiplicand when the current multiplier LSB is set.
module mul8_iter
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            load,
  input  logic            step,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [2*DW-1:0] product_nxt
);

  logic [2*DW-1:0] mcand_q, mcand_d;
  logic [2*DW-1:0] prod_q, prod_d;
  logic [DW-1:0]   mplier_q, mplier_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    if (load) begin
      mcand_d  = {{DW{1'b0}}, a};
      mplier_d = b;
      prod_d   = '0;
    end else if (step) begin
      if (mplier_q[0]) prod_d = prod_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
    // Exposing the post-step value lets the caller capture the product on the last step.
    product_nxt = prod_d;
  end

  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    prod_q   <= prod_d;
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU ops, iterative one-bit-per-cycle shifts and a
// shift-add multiply, with a start/busy/done handshake and reg_file write-back.
module exec_unit
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  exec_unit_if.slave bus
);

  localparam int CNT_W = $clog2(DW + 1);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sh_cout_q, sh_cout_d;
  logic [DW-1:0]    wd_q, wd_d;
  logic             co_q, co_d;

  logic             mul_load, mul_step;
  logic [2*DW-1:0]  mul_prod;
  logic [SHAMT_W-1:0] shamt_in;
  logic             start_multi;
  logic [DW:0]      alu_res;

  // {cout, result} for every op that completes in the accept cycle.
  function automatic logic [DW:0] alu_single(op_t op, logic [DW-1:0] a, logic [DW-1:0] b,
                                             logic c);
    logic [DW:0] r;
    case (op)
      OP_ADD:         r = {1'b0, a} + {1'b0, b};
      OP_ADC:         r = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, c};
      OP_SUB, OP_CMP: r = {(a < b), a - b};
      OP_AND:         r = {c, a & b};
      OP_OR:          r = {c, a | b};
      OP_XOR:         r = {c, a ^ b};
      OP_PASS:        r = {c, b};
      OP_SHL, OP_SHR: r = {1'b0, a};
      default:        r = '0;
    endcase
    return r;
  endfunction

  assign shamt_in    = bus.rt_val[SHAMT_W-1:0];
  assign start_multi = (bus.op == OP_MUL) ||
                       (((bus.op == OP_SHL) || (bus.op == OP_SHR)) && (shamt_in != '0));
  assign alu_res     = alu_single(bus.op, bus.rs_val, bus.rt_val, bus.cin);

  mul8_iter u_mul (
    .clk         (clk),
    .load        (mul_load),
    .step        (mul_step),
    .a           (bus.rs_val),
    .b           (bus.rt_val),
    .product_nxt (mul_prod)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = start_multi ? RUN : DONE;
      RUN:     if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_d      = op_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sh_cout_d = sh_cout_q;
    wd_d      = wd_q;
    co_d      = co_q;
    mul_load  = 1'b0;
    mul_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d      = bus.op;
          acc_d     = bus.rs_val;
          sh_cout_d = 1'b0;
          cnt_d     = (bus.op == OP_MUL) ? CNT_W'(DW) : CNT_W'(shamt_in);
          mul_load  = (bus.op == OP_MUL);
          if (!start_multi) {co_d, wd_d} = alu_res;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 1'b1;
        case (op_q)
          OP_SHL: begin
            acc_d     = acc_q << 1;
            sh_cout_d = acc_q[DW-1];
          end
          OP_SHR: begin
            acc_d     = acc_q >> 1;
            sh_cout_d = acc_q[0];
          end
          OP_MUL:  mul_step = 1'b1;
          default: ;
        endcase
        // Results are committed on the final RUN cycle so they appear together with done.
        if (cnt_q == CNT_W'(1)) begin
          if (op_q == OP_MUL) begin
            wd_d = mul_prod[DW-1:0];
            co_d = |mul_prod[2*DW-1:DW];
          end else begin
            wd_d = acc_d;
            co_d = sh_cout_d;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.busy              = (state_q != IDLE);
    bus.done              = (state_q == DONE);
    bus.write_data        = wd_q;
    bus.cout_data         = co_q;
    bus.write_enable      = (state_q == DONE) && op_writes_reg(op_q);
    bus.cout_write_enable = (state_q == DONE) && op_writes_carry(op_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      cnt_q   <= '0;
      wd_q    <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      co_q    <= co_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q     <= acc_d;
    sh_cout_q <= sh_cout_d;
  end

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: directed literal cases plus randomized traffic, all checked
// every cycle against a cycle-count/arithmetic reference model.
module tb_exec_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  exec_unit_if bus();

  exec_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Reference model state
  int cyc = 0;
  bit in_flight = 1'b0;
  int done_at = 0;
  int e_r, e_co;
  bit e_we, e_cwe, e_rv, e_cv;
  int held_wd = 0, held_co = 0;
  bit wd_v = 1'b1, co_v = 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic ref_op(input logic [3:0] op, input int a, input int b, input int c,
                        output int r, output int co, output bit we, output bit cwe,
                        output bit rv, output bit cv, output int k);
    int s;
    r = 0; co = 0; we = 1'b1; cwe = 1'b0; rv = 1'b1; cv = 1'b0; k = 0;
    case (op_t'(op))
      OP_ADD:  begin s = a + b;     r = s % 256; co = s / 256; cwe = 1; cv = 1; end
      OP_ADC:  begin s = a + b + c; r = s % 256; co = s / 256; cwe = 1; cv = 1; end
      OP_SUB:  begin r = (a - b + 256) % 256; co = (a < b) ? 1 : 0; cwe = 1; cv = 1; end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_PASS: r = b;
      OP_CMP:  begin we = 0; rv = 0; co = (a < b) ? 1 : 0; cwe = 1; cv = 1; end
      OP_SHL: begin
        k = b % 8; r = (a << k) % 256; co = (k != 0) ? ((a >> (8 - k)) & 1) : 0; cwe = 1; cv = 1;
      end
      OP_SHR: begin
        k = b % 8; r = a >> k; co = (k != 0) ? ((a >> (k - 1)) & 1) : 0; cwe = 1; cv = 1;
      end
      OP_MUL:  begin k = 8; s = a * b; r = s % 256; co = (s > 255) ? 1 : 0; cwe = 1; cv = 1; end
      default: begin r = 0; we = 0; cwe = 0; end
    endcase
  endtask

  always @(posedge clk) begin
    int k;
    if (!reset_n) begin
      in_flight = 1'b0;
      held_wd = 0; held_co = 0; wd_v = 1'b1; co_v = 1'b1;
    end else if (!(in_flight && cyc <= done_at) && bus.start === 1'b1) begin
      ref_op(bus.op, int'(bus.rs_val), int'(bus.rt_val), int'(bus.cin),
             e_r, e_co, e_we, e_cwe, e_rv, e_cv, k);
      in_flight = 1'b1;
      done_at = cyc + 1 + k;
    end
    cyc++;
    if (reset_n && in_flight && cyc == done_at) begin
      held_wd = e_r;  wd_v = e_rv;
      held_co = e_co; co_v = e_cv;
    end
  end

  always @(negedge clk) begin
    bit busy_e, done_e;
    if (chk_en) begin
      busy_e = in_flight && (cyc <= done_at);
      done_e = in_flight && (cyc == done_at);
      chk("busy", bus.busy, busy_e);
      chk("done", bus.done, done_e);
      chk("write_enable", bus.write_enable, done_e && e_we);
      chk("cout_write_enable", bus.cout_write_enable, done_e && e_cwe);
      if (wd_v) chk("write_data", bus.write_data, held_wd);
      if (co_v) chk("cout_data", bus.cout_data, held_co);
    end
  end

  task automatic drive_busy_cycle(input bit spam);
    bus.start  = spam;
    bus.op     = op_t'($urandom_range(0, 7));
    bus.rs_val = 8'($urandom);
    bus.rt_val = 8'($urandom);
    bus.cin    = 1'($urandom);
  endtask

  task automatic run_op(input string nm, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic c, input bit spam, input int exp_lat,
                        input logic [7:0] exp_wd, input bit chk_wd, input logic exp_co,
                        input bit chk_co, input logic exp_we, input logic exp_cwe);
    int lat = 0;
    bit seen = 1'b0;
    @(posedge clk); #2;
    bus.start = 1'b1; bus.op = op_t'(op); bus.rs_val = a; bus.rt_val = b; bus.cin = c;
    @(posedge clk); #2;
    drive_busy_cycle(spam);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #2;
      drive_busy_cycle(spam);
    end
    if (seen) begin
      chk({nm, "_latency"}, lat, exp_lat);
      if (chk_wd) chk({nm, "_wd"}, bus.write_data, exp_wd);
      if (chk_co) chk({nm, "_cout"}, bus.cout_data, exp_co);
      chk({nm, "_we"}, bus.write_enable, exp_we);
      chk({nm, "_cwe"}, bus.cout_write_enable, exp_cwe);
    end else begin
      chk({nm, "_done_timeout"}, 0, 1);
    end
    @(posedge clk); #2;
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.op = OP_ADD; bus.rs_val = '0; bus.rt_val = '0; bus.cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_wd", bus.write_data, 0);
    chk("rst_cout", bus.cout_data, 0);
    chk("rst_we", bus.write_enable, 0);
    chk("rst_cwe", bus.cout_write_enable, 0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    chk_en = 1'b1;

    run_op("add",   4'd0,  8'hF0, 8'h20, 1'b0, 0, 1, 8'h10, 1, 1'b1, 1, 1'b1, 1'b1);
    run_op("adc",   4'd1,  8'hFF, 8'h00, 1'b1, 0, 1, 8'h00, 1, 1'b1, 1, 1'b1, 1'b1);
    run_op("sub",   4'd2,  8'h05, 8'h07, 1'b0, 0, 1, 8'hFE, 1, 1'b1, 1, 1'b1, 1'b1);
    run_op("cmp",   4'd7,  8'h03, 8'h03, 1'b1, 0, 1, 8'h00, 0, 1'b0, 1, 1'b0, 1'b1);
    run_op("and",   4'd3,  8'hAA, 8'h0F, 1'b0, 0, 1, 8'h0A, 1, 1'b0, 0, 1'b1, 1'b0);
    run_op("shr",   4'd9,  8'h81, 8'h01, 1'b0, 0, 2, 8'h40, 1, 1'b1, 1, 1'b1, 1'b1);
    run_op("shl",   4'd8,  8'h81, 8'h03, 1'b0, 0, 4, 8'h08, 1, 1'b0, 1, 1'b1, 1'b1);
    run_op("shl_k0", 4'd8, 8'h81, 8'h08, 1'b1, 0, 1, 8'h81, 1, 1'b0, 1, 1'b1, 1'b1);
    run_op("mul_a", 4'd10, 8'h10, 8'h11, 1'b0, 0, 9, 8'h10, 1, 1'b1, 1, 1'b1, 1'b1);
    run_op("mul_b", 4'd10, 8'h0F, 8'h03, 1'b0, 0, 9, 8'h2D, 1, 1'b0, 1, 1'b1, 1'b1);
    run_op("mul_spam", 4'd10, 8'h10, 8'h11, 1'b0, 1, 9, 8'h10, 1, 1'b1, 1, 1'b1, 1'b1);
    run_op("undef", 4'd12, 8'h55, 8'h66, 1'b1, 0, 1, 8'h00, 1, 1'b0, 0, 1'b0, 1'b0);

    // Reset during the fourth RUN cycle of a multiply
    @(posedge clk); #2;
    bus.start = 1'b1; bus.op = OP_MUL; bus.rs_val = 8'h10; bus.rt_val = 8'h11;
    @(posedge clk); #2;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_wd", bus.write_data, 0);
    chk("midrst_cout", bus.cout_data, 0);
    chk("midrst_we", bus.write_enable, 0);
    repeat (12) @(posedge clk);
    run_op("add_after_rst", 4'd0, 8'hF0, 8'h20, 1'b0, 0, 1, 8'h10, 1, 1'b1, 1, 1'b1, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #2;
      reset_n    = ($urandom_range(0, 149) != 0);
      bus.start  = 1'($urandom);
      bus.op     = op_t'($urandom_range(0, 15));
      bus.rs_val = 8'($urandom);
      bus.rt_val = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      bus.cin    = 1'($urandom);
    end
    @(posedge clk); #2;
    reset_n = 1'b1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
